// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry look-ahead adder family:
// default group size, per-stage control record and elaboration checks.
package cla_pkg;

    // Default number of bits handled by one look-ahead group.
    localparam int CLA_GROUP_DEFAULT = 4;

    // Control part of a pipeline stage record. The partial-sum word (low
    // bits already added, high bits still holding operand A) and the
    // remaining operand-B word are width-dependent, so the top sizes them.
    typedef struct packed {
        logic valid;   // stage holds a live transaction
        logic carry;   // carry out of the highest bit added so far
    } cla_stage_ctl_t;

    // Operand width must be at least 4 and split evenly across the stages.
    function automatic bit cla_stages_ok(input int width, input int stages);
        return (width >= 4) && (stages >= 1) && ((width % stages) == 0);
    endfunction

    // Each stage segment must hold a whole number of look-ahead groups.
    function automatic bit cla_group_ok(input int width, input int stages, input int group);
        return (group >= 1) && (stages >= 1) && (((width / stages) % group) == 0);
    endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GW-bit carry look-ahead slice. Produces the slice sum for a
// given carry-in plus group propagate/generate for the look-ahead unit.
// P and G are computed apart from s so they never depend on c.
module cla_group #(
    parameter int GW = 4
) (
    input  logic [GW-1:0] a,
    input  logic [GW-1:0] b,
    input  logic          c,
    output logic [GW-1:0] s,
    output logic          P,
    output logic          G
);

    logic [GW-1:0] p;
    logic [GW-1:0] g;
    logic [GW-1:0] cc;

    assign p = a ^ b;
    assign g = a & b;

    // Group propagate/generate from bit-level terms, independent of c.
    always_comb begin
        P = &p;
        G = 1'b0;
        for (int i = 0; i < GW; i++) begin
            G = g[i] | (p[i] & G);
        end
    end

    // Bit carries inside the slice and the resulting sum bits.
    always_comb begin
        cc    = '0;
        cc[0] = c;
        for (int i = 1; i < GW; i++) begin
            cc[i] = g[i-1] | (p[i-1] & cc[i-1]);
        end
        s = p ^ cc;
    end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Elastic pipelined carry look-ahead adder. Stage k adds operand segment k
// with the carry registered by stage k-1; valid/ready on both sides, no skid.
// Optional feature macro: CLA_OVERFLOW_EN adds the signed-overflow port ovf.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter int GROUP  = CLA_GROUP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int SEG = WIDTH / STAGES;
    localparam int NG  = SEG / GROUP;

    if (!cla_stages_ok(WIDTH, STAGES)) begin : g_bad_stages
        $error("pipelined_cla_adder: WIDTH must be >= 4 and divisible by STAGES");
    end
    if (!cla_group_ok(WIDTH, STAGES, GROUP)) begin : g_bad_group
        $error("pipelined_cla_adder: WIDTH/STAGES must be divisible by GROUP");
    end

    cla_stage_ctl_t   st_ctl [STAGES];
    logic [WIDTH-1:0] st_x   [STAGES];  // sum bits below the segment boundary, operand A above
    logic [WIDTH-1:0] st_y   [STAGES];  // zeros below the boundary, operand B above
    logic [STAGES-1:0] take;            // stage k loads this cycle
`ifdef CLA_OVERFLOW_EN
    logic ovf_q;
`endif

    // A stage loads when it is empty or its content moves on; evaluated from the output back.
    always_comb begin : p_take
        logic go;
        go   = out_ready;
        take = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            take[k] = !st_ctl[k].valid || go;
            go      = take[k];
        end
    end

    assign in_ready = take[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SEG;

        logic [WIDTH-1:0] sx, sy;
        logic             sc, sv;
        logic [NG-1:0]    gp, gg;
        logic [NG:0]      cg;
        logic [SEG-1:0]   ss;
        logic [WIDTH-1:0] x_d, y_d, x_q, y_q;
        cla_stage_ctl_t   ctl_q;

        if (k == 0) begin : g_head
            assign sx = a;
            assign sy = b;
            assign sc = cin;
            assign sv = in_valid;
        end else begin : g_body
            assign sx = st_x[k-1];
            assign sy = st_y[k-1];
            assign sc = st_ctl[k-1].carry;
            assign sv = st_ctl[k-1].valid;
        end

        for (genvar j = 0; j < NG; j++) begin : g_grp
            cla_group #(.GW(GROUP)) u_grp (
                .a (sx[LO + j*GROUP +: GROUP]),
                .b (sy[LO + j*GROUP +: GROUP]),
                .c (cg[j]),
                .s (ss[j*GROUP +: GROUP]),
                .P (gp[j]),
                .G (gg[j])
            );
        end

        // Flat look-ahead: each group carry is a sum of products, no ripple between groups.
        always_comb begin
            logic term;
            cg    = '0;
            cg[0] = sc;
            term  = 1'b0;
            for (int j = 1; j <= NG; j++) begin
                cg[j] = sc;
                for (int m = 0; m < j; m++) cg[j] = cg[j] & gp[m];
                for (int i = 0; i < j; i++) begin
                    term = gg[i];
                    for (int m = i + 1; m < j; m++) term = term & gp[m];
                    cg[j] = cg[j] | term;
                end
            end
        end

        // Replace segment k with its sum bits; clear the consumed B bits.
        always_comb begin
            x_d             = sx;
            x_d[LO +: SEG]  = ss;
            y_d             = sy;
            y_d[LO +: SEG]  = '0;
        end

        // Stage register: valid, carry and data words advance together.
        always_ff @(posedge clk) begin
            if (rst) begin
                ctl_q <= '0;
                x_q   <= '0;
                y_q   <= '0;
            end else if (take[k]) begin
                ctl_q.valid <= sv;
                ctl_q.carry <= cg[NG];
                x_q         <= x_d;
                y_q         <= y_d;
            end
        end

        assign st_ctl[k] = ctl_q;
        assign st_x[k]   = x_q;
        assign st_y[k]   = y_q;

`ifdef CLA_OVERFLOW_EN
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_d;
            // Carry into the MSB is recovered from the MSB sum and operand bits.
            assign ovf_d = (ss[SEG-1] ^ sx[WIDTH-1] ^ sy[WIDTH-1]) ^ cg[NG];

            // Overflow flag registered alongside the last stage.
            always_ff @(posedge clk) begin
                if (rst)          ovf_q <= 1'b0;
                else if (take[k]) ovf_q <= ovf_d;
            end
        end
`endif
    end

    // The last stage's B word is all zeros by construction and feeds nothing.
    logic unused_tail_y;
    assign unused_tail_y = ^st_y[STAGES-1];

    assign out_valid = st_ctl[STAGES-1].valid;
    assign sum       = st_x[STAGES-1];
    assign cout      = st_ctl[STAGES-1].carry;
`ifdef CLA_OVERFLOW_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder (WIDTH=16, STAGES=4, GROUP=4).
// The driver pushes hand-computed expectations on each accepted input; an
// independent monitor pops and compares whenever a result is handed off.
module tb_pipelined_cla_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [W-1:0] a, b, sum;
`ifdef CLA_OVERFLOW_EN
    logic         ovf;
`endif

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    typedef struct {
        logic [W-1:0] a, b;
        logic         ci;
        logic [W-1:0] s;
        logic         co, o;
    } vec_t;

    exp_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   stalls   = 0;
    int   bp_acc   = 0;
    bit   bp_watch = 1'b0;

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(16), .STAGES(4), .GROUP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    // Present one operand set until accepted; queue its expected result.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic [W-1:0] es, input logic ec, input logic eo);
        exp_t e;
        bit   done;
        done = 1'b0;
        e.s = es; e.c = ec; e.o = eo;
        in_valid = 1'b1; a = ta; b = tb_v; cin = tc;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(e);
                done = 1'b1;
                if (bp_watch) bp_acc++;
            end else begin
                stalls++;
                if (bp_watch) begin
                    chk("bp_accepts_before_stall", bp_acc, 4);
                    bp_watch = 1'b0;
                end
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles");
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && q.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        chk("drain_queue_empty", q.size(), 0);
    endtask

    // Monitor: compare on every handoff, and check held data while stalled.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result: sum=0x%0h cout=%0b with empty scoreboard", sum, cout);
            end else if (out_ready) begin
                exp_t e;
                e = q.pop_front();
                chk("result_sum", sum, e.s);
                chk("result_cout", cout, e.c);
`ifdef CLA_OVERFLOW_EN
                chk("result_ovf", ovf, e.o);
`endif
            end else begin
                chk("stall_hold_sum", sum, q[0].s);
                chk("stall_hold_cout", cout, q[0].c);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   n_ov, n_late;
        vecs = '{
            '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0},
            '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1},
            '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0},
            '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1},
            '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0},
            '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0},
            '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0}
        };

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_sum", sum, 0);
        chk("reset_cout", cout, 0);
        chk("reset_in_ready", in_ready, 1);
`ifdef CLA_OVERFLOW_EN
        chk("reset_ovf", ovf, 0);
`endif
        @(posedge clk); #1;

        // Single transfer and latency
        send(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
        in_valid = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            chk($sformatf("latency_out_valid_c%0d", n), out_valid, (n == 4));
        end
        @(posedge clk); #1;
        drain();

        // Directed corner vectors, back to back
        foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].co, vecs[i].o);
        in_valid = 1'b0;
        drain();

        // Backpressure: consumer stalls for 6 cycles while 8 pairs stream in
        out_ready = 1'b0;
        bp_acc = 0;
        bp_watch = 1'b1;
        fork
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 8; i++) send(W'(i), W'(2 * i), 1'b0, W'(3 * i), 1'b0, 1'b0);
                in_valid = 1'b0;
            end
        join
        drain();
        chk("bp_in_ready_fell", bp_watch, 0);
        bp_watch = 1'b0;

        // Full throughput with random operands
        stalls = 0;
        n_ov = 0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    logic [W-1:0] ra, rb;
                    logic         rc, ro;
                    logic [W:0]   t;
                    ra = W'($urandom);
                    rb = W'($urandom);
                    rc = 1'($urandom_range(0, 1));
                    t  = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
                    ro = (ra[W-1] == rb[W-1]) && (t[W-1] != ra[W-1]);
                    send(ra, rb, rc, t[W-1:0], t[W], ro);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (104) begin
                    @(negedge clk);
                    if (out_valid) n_ov++;
                end
            end
        join
        chk("tput_input_stalls", stalls, 0);
        chk("tput_results_in_window", n_ov, 100);
        drain();

        // Mid-stream reset discards three in-flight transactions
        send(16'h0011, 16'h0022, 1'b0, 16'h0033, 1'b0, 1'b0);
        send(16'h0100, 16'h0200, 1'b0, 16'h0300, 1'b0, 1'b0);
        send(16'h1000, 16'h2000, 1'b1, 16'h3001, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_flush_out_valid", out_valid, 0);
        chk("rst_flush_in_ready", in_ready, 1);
        n_late = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) n_late++;
        end
        chk("rst_no_ghost_results", n_late, 0);
        @(posedge clk); #1;

        // Pipeline still works after the flush
        send(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);
        in_valid = 1'b0;
        drain();

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
